// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and defaults for the data-memory arbiter slice.
// Used by dmem_arbiter, dmem_arb_pick and dmem_arbiter_if.
package dmem_pkg;

    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 10;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } dmem_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports, clear control and memory pins.
// slave = arbiter side, master = requester/memory environment side.
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int BUS_WIDTH  = DMEM_ADDR_W
);

    logic                  p0_req;
    logic                  p0_we;
    logic [BUS_WIDTH-1:0]  p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_gnt;
    logic [DATA_WIDTH-1:0] p0_rdata;
    logic                  p0_rvalid;

    logic                  p1_req;
    logic                  p1_we;
    logic [BUS_WIDTH-1:0]  p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_gnt;
    logic [DATA_WIDTH-1:0] p1_rdata;
    logic                  p1_rvalid;

    logic                  clr_start;
    logic                  clr_busy;
    logic                  clr_done;

    logic                  mem_read;
    logic                  mem_write;
    logic [BUS_WIDTH-1:0]  mem_A;
    logic [DATA_WIDTH-1:0] mem_D;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  p0_req, p0_we, p0_addr, p0_wdata,
        output p0_gnt, p0_rdata, p0_rvalid,
        input  p1_req, p1_we, p1_addr, p1_wdata,
        output p1_gnt, p1_rdata, p1_rvalid,
        input  clr_start,
        output clr_busy, clr_done,
        output mem_read, mem_write, mem_A, mem_D,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_we, p0_addr, p0_wdata,
        input  p0_gnt, p0_rdata, p0_rvalid,
        output p1_req, p1_we, p1_addr, p1_wdata,
        input  p1_gnt, p1_rdata, p1_rvalid,
        output clr_start,
        input  clr_busy, clr_done,
        input  mem_read, mem_write, mem_A, mem_D,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational 2-way grant selector, onehot output.
// rr_en=0 gives fixed priority to port 0; rr_en=1 favours rr_ptr.
module dmem_arb_pick
    import dmem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_ptr,
    input  logic       rr_en,
    output logic [1:0] gnt
);

    logic pref_dbg;
    logic sel_dbg;
    logic sel_cpu;

    always_comb begin
        pref_dbg = rr_en & rr_ptr;
        sel_dbg  = req[PORT_DBG] & (pref_dbg | ~req[PORT_CPU]);
        sel_cpu  = req[PORT_CPU] & ~sel_dbg;
        gnt      = 2'b00;
        gnt[PORT_DBG] = sel_dbg;
        gnt[PORT_CPU] = sel_cpu;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between CPU and debug ports and
// sequences a word-per-cycle clear. DMEM_ARB_RR_EN selects round-robin.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int BUS_WIDTH  = DMEM_ADDR_W
) (
    input logic           clk,
    input logic           RST_n,
    dmem_arbiter_if.slave bus
);

    dmem_state_e state_q, state_d;

    logic [BUS_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
    logic                  rv0_q, rv0_d;
    logic                  rv1_q, rv1_d;
    logic                  done_q, done_d;
    logic                  ptr_q;

    logic [1:0] req;
    logic [1:0] pick;
    logic [1:0] gnt;
    logic       arb_en;
    logic       last;

`ifdef DMEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;

    logic ptr_d;

    // pointer names the port that did not win last
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt) ptr_d = gnt[PORT_CPU];
    end

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end
`else
    localparam logic RR_EN = 1'b0;

    assign ptr_q = 1'b0;
`endif

    assign req = {bus.p1_req, bus.p0_req};

    dmem_arb_pick u_pick (
        .req    (req),
        .rr_ptr (ptr_q),
        .rr_en  (RR_EN),
        .gnt    (pick)
    );

    // a clr_start cycle pre-empts arbitration
    assign arb_en = RST_n & (state_q == ST_IDLE) & ~bus.clr_start;
    assign gnt    = arb_en ? pick : 2'b00;
    assign last   = &cnt_q;

    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
            rv0_q   <= rv0_d;
            rv1_q   <= rv1_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + BUS_WIDTH'(1);
                if (last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rv0_d = gnt[PORT_CPU] & ~bus.p0_we;
        rv1_d = gnt[PORT_DBG] & ~bus.p1_we;
        rd0_d = rv0_d ? bus.mem_rdata : rd0_q;
        rd1_d = rv1_d ? bus.mem_rdata : rd1_q;
    end

    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_A     = '0;
        bus.mem_D     = '0;
        unique case (1'b1)
            (state_q == ST_CLEAR): begin
                bus.mem_write = 1'b1;
                bus.mem_A     = cnt_q;
            end
            gnt[PORT_CPU]: begin
                bus.mem_read  = ~bus.p0_we;
                bus.mem_write = bus.p0_we;
                bus.mem_A     = bus.p0_addr;
                bus.mem_D     = bus.p0_we ? bus.p0_wdata : '0;
            end
            gnt[PORT_DBG]: begin
                bus.mem_read  = ~bus.p1_we;
                bus.mem_write = bus.p1_we;
                bus.mem_A     = bus.p1_addr;
                bus.mem_D     = bus.p1_we ? bus.p1_wdata : '0;
            end
            default: ;
        endcase

        bus.p0_gnt    = gnt[PORT_CPU];
        bus.p1_gnt    = gnt[PORT_DBG];
        bus.p0_rdata  = rd0_q;
        bus.p1_rdata  = rd1_q;
        bus.p0_rvalid = rv0_q;
        bus.p1_rvalid = rv1_q;
        bus.clr_busy  = (state_q == ST_CLEAR);
        bus.clr_done  = done_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, directed clear sequences and a
// randomized two-port run checked against a queue-free request model.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic RST_n = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .BUS_WIDTH(AW)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .BUS_WIDTH(AW)) dut (
        .clk   (clk),
        .RST_n (RST_n),
        .bus   (bus)
    );

    // memory: combinational read, write on posedge
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    always @(posedge clk)
        if (bus.mem_write) mem[bus.mem_A] <= bus.mem_D;

    assign bus.mem_rdata = mem[bus.mem_A];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input bit r, input bit we,
                              input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_req = r; bus.p0_we = we;
            bus.p0_addr = a; bus.p0_wdata = d;
        end else begin
            bus.p1_req = r; bus.p1_we = we;
            bus.p1_addr = a; bus.p1_wdata = d;
        end
    endtask

    task automatic idle_in();
        drive_port(0, 0, 0, '0, '0);
        drive_port(1, 0, 0, '0, '0);
        bus.clr_start = 1'b0;
    endtask

    // one access on one port; bounded wait for the grant
    task automatic access(input int p, input bit we,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string nm,
                          output logic [DW-1:0] rdata);
        bit got;
        got = 0;
        rdata = '0;
        tick();
        drive_port(p, 1, we, a, d);
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? bus.p0_gnt : bus.p1_gnt;
            if (!got) tick();
        end
        chk({nm, " gnt"}, got, 1);
        tick();
        drive_port(p, 0, 0, '0, '0);
        if (!we) begin
            @(negedge clk);
            chk({nm, " rvalid"},
                (p == 0) ? bus.p0_rvalid : bus.p1_rvalid, 1);
            rdata = (p == 0) ? bus.p0_rdata : bus.p1_rdata;
            tick();
            @(negedge clk);
            chk({nm, " rvalid drop"},
                (p == 0) ? bus.p0_rvalid : bus.p1_rvalid, 0);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        RST_n = 1'b0;
        @(negedge clk);
        RST_n = 1'b1;
    endtask

    task automatic run_clear(input int abort_at, input int repulse_at,
                             input bit hold_p1, output int busy_n,
                             output int done_n, output int bad_n,
                             output int g_busy, output bit g1_done);
        int  tail;
        bit  drop_p1;
        busy_n = 0; done_n = 0; bad_n = 0; g_busy = 0;
        g1_done = 0; tail = -1; drop_p1 = 0;
        tick();
        bus.clr_start = 1'b1;
        if (hold_p1) drive_port(1, 1, 0, AW'(9), '0);
        @(negedge clk);
        chk("clr start cycle idle",
            {bus.p0_gnt, bus.p1_gnt, bus.mem_read,
             bus.mem_write, bus.clr_busy}, 0);
        tick();
        bus.clr_start = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            if (bus.clr_busy) begin
                if (bus.mem_A != AW'(busy_n) || !bus.mem_write ||
                    bus.mem_D != '0 || bus.mem_read)
                    bad_n++;
                if (bus.p0_gnt || bus.p1_gnt) g_busy++;
                if (abort_at >= 0 && busy_n == abort_at) begin
                    #1 RST_n = 1'b0;
                    #1;
                    chk("abort ctl zero",
                        {bus.p0_gnt, bus.p0_rvalid, bus.p1_gnt,
                         bus.p1_rvalid, bus.clr_busy, bus.clr_done,
                         bus.mem_read, bus.mem_write}, 0);
                    chk("abort A/D zero", {bus.mem_A, bus.mem_D}, 0);
                    chk("abort rdata zero",
                        {bus.p0_rdata, bus.p1_rdata}, 0);
                    @(negedge clk);
                    @(negedge clk);
                    RST_n = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        if (bus.clr_done) done_n++;
                    end
                    return;
                end
                busy_n++;
            end
            if (bus.clr_done) begin
                done_n++;
                g1_done = bus.p1_gnt;
                if (tail < 0) tail = c;
            end
            if (bus.p1_gnt) drop_p1 = 1;
            if (tail >= 0 && c >= tail + 3) break;
            tick();
            bus.clr_start = (repulse_at >= 0 && busy_n == repulse_at);
            if (drop_p1) drive_port(1, 0, 0, '0, '0);
        end
        bus.clr_start = 1'b0;
    endtask

    typedef struct {
        bit r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        bit r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        bit g0, g1, rd, wr;
        logic [AW-1:0] ea; logic [DW-1:0] ed;
    } vec_t;

    function automatic vec_t mk(bit r0, bit w0, int a0, logic [DW-1:0] d0,
                                bit r1, bit w1, int a1, logic [DW-1:0] d1,
                                bit g0, bit g1, bit rd, bit wr,
                                int ea, logic [DW-1:0] ed);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = AW'(a0); v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = AW'(a1); v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rd = rd; v.wr = wr;
        v.ea = AW'(ea); v.ed = ed;
        return v;
    endfunction

    typedef struct {
        bit v; bit we; logic [AW-1:0] a; logic [DW-1:0] d;
    } req_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vt[$];
        logic [DW-1:0] rd;
        logic [3:0]    g0v, g1v;
        int            bn, dn, bad, gb;
        bit            g1d;
        req_t          pend [2];
        bit            exp_rv [2];
        logic [DW-1:0] exp_rd [2];
        bit            pref;
        int            w;

        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        idle_in();

        // reset: a pending request must not leak a grant
        drive_port(0, 1, 0, AW'(3), '0);
        #12;
        chk("reset ctl zero",
            {bus.p0_gnt, bus.p0_rvalid, bus.p1_gnt, bus.p1_rvalid,
             bus.clr_busy, bus.clr_done, bus.mem_read, bus.mem_write},
            0);
        chk("reset A/D zero", {bus.mem_A, bus.mem_D}, 0);
        idle_in();
        @(negedge clk);
        RST_n = 1'b1;

        vt.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0));
        vt.push_back(mk(1,0,2,0, 0,0,0,0, 1,0,1,0, 2,0));
        vt.push_back(mk(1,1,4,32'h11, 0,0,0,0, 1,0,0,1, 4,32'h11));
        vt.push_back(mk(0,0,0,0, 1,0,6,0, 0,1,1,0, 6,0));
        vt.push_back(mk(0,0,0,0, 1,1,8,32'h22, 0,1,0,1, 8,32'h22));
`ifndef DMEM_ARB_RR_EN
        vt.push_back(mk(1,0,3,0, 1,1,9,32'h33, 1,0,1,0, 3,0));
        vt.push_back(mk(1,1,10,32'h44, 1,0,11,0, 1,0,0,1, 10,32'h44));
`endif
        vt.push_back(mk(0,1,13,32'h55, 1,0,12,0, 0,1,1,0, 12,0));
        vt.push_back(mk(0,1,14,32'h66, 0,1,15,32'h77, 0,0,0,0, 0,0));

        foreach (vt[i]) begin
            tick();
            drive_port(0, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0);
            drive_port(1, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {bus.p0_gnt, bus.p1_gnt, bus.mem_read, bus.mem_write,
                 bus.mem_A, bus.mem_D},
                {vt[i].g0, vt[i].g1, vt[i].rd, vt[i].wr,
                 vt[i].ea, vt[i].ed});
        end
        tick();
        idle_in();

        // write then read back on port 0
        access(0, 1, AW'(5), 32'hDEADBEEF, "t1 wr", rd);
        access(0, 0, AW'(5), '0, "t1 rd", rd);
        chk("t1 rdata", rd, 32'hDEADBEEF);

        // contention held for four cycles
        reset_pulse();
        tick();
        drive_port(0, 1, 0, AW'(3), '0);
        drive_port(1, 1, 0, AW'(7), '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g0v[i] = bus.p0_gnt;
            g1v[i] = bus.p1_gnt;
            tick();
        end
        idle_in();
`ifdef DMEM_ARB_RR_EN
        chk("t2 rr p0 pattern", g0v, 4'b0101);
        chk("t2 rr p1 pattern", g1v, 4'b1010);
`else
        chk("t2 fixed p0 pattern", g0v, 4'b1111);
        chk("t2 fixed p1 pattern", g1v, 4'b0000);
`endif

        // randomized traffic on addresses 16..31
        reset_pulse();
        pend[0].v = 0; pend[1].v = 0;
        exp_rv[0] = 0; exp_rv[1] = 0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        pref = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].v && $urandom_range(0, 1) == 1) begin
                    pend[p].v  = 1;
                    pend[p].we = 1'($urandom_range(0, 1));
                    pend[p].a  = AW'(16 + $urandom_range(0, 15));
                    pend[p].d  = $urandom;
                end
                drive_port(p, pend[p].v, pend[p].we & pend[p].v,
                           pend[p].a, pend[p].d);
            end
            @(negedge clk);
            if (pend[0].v && pend[1].v) w = (RR && pref) ? 1 : 0;
            else if (pend[0].v)         w = 0;
            else if (pend[1].v)         w = 1;
            else                        w = -1;
            chk("rand gnt", {bus.p1_gnt, bus.p0_gnt},
                {w == 1, w == 0});
            chk("rand rvalid", {bus.p1_rvalid, bus.p0_rvalid},
                {exp_rv[1], exp_rv[0]});
            if (exp_rv[0]) chk("rand p0 rdata", bus.p0_rdata, exp_rd[0]);
            if (exp_rv[1]) chk("rand p1 rdata", bus.p1_rdata, exp_rd[1]);
            exp_rv[0] = 0; exp_rv[1] = 0;
            if (w >= 0) begin
                if (pend[w].we) ref_mem[pend[w].a] = pend[w].d;
                else begin
                    exp_rv[w] = 1;
                    exp_rd[w] = ref_mem[pend[w].a];
                end
                pend[w].v = 0;
                pref = (w == 0);
            end
        end
        tick();
        idle_in();

        // full clear
        access(0, 1, AW'(0), 32'h1, "t3 w0", rd);
        access(0, 1, AW'(511), 32'h1, "t3 w511", rd);
        access(1, 1, AW'(1023), 32'h1, "t3 w1023", rd);
        run_clear(-1, -1, 0, bn, dn, bad, gb, g1d);
        chk("t3 busy cycles", bn, 1024);
        chk("t3 done pulses", dn, 1);
        chk("t3 clear writes", bad, 0);
        chk("t3 no grants", gb, 0);
        access(0, 0, AW'(0), '0, "t3 r0", rd);
        chk("t3 addr0", rd, 0);
        access(1, 0, AW'(511), '0, "t3 r511", rd);
        chk("t3 addr511", rd, 0);
        access(0, 0, AW'(1023), '0, "t3 r1023", rd);
        chk("t3 addr1023", rd, 0);

        // port 1 waits through the clear
        run_clear(-1, -1, 1, bn, dn, bad, gb, g1d);
        chk("t4 no gnt in clear", gb, 0);
        chk("t4 gnt at done", g1d, 1);
        chk("t4 done pulses", dn, 1);
        idle_in();

        // restart request mid-clear is ignored
        run_clear(-1, 50, 0, bn, dn, bad, gb, g1d);
        chk("t6 busy cycles", bn, 1024);
        chk("t6 clear writes", bad, 0);
        chk("t6 done pulses", dn, 1);

        // reset aborts the clear
        access(0, 1, AW'(200), 32'hA5A50200, "t5 w200", rd);
        access(0, 1, AW'(50), 32'h5, "t5 w50", rd);
        run_clear(100, -1, 0, bn, dn, bad, gb, g1d);
        chk("t5 no done", dn, 0);
        chk("t5 counter at abort", bn, 100);
        access(0, 0, AW'(200), '0, "t5 r200", rd);
        chk("t5 addr200 kept", rd, 32'hA5A50200);
        access(1, 0, AW'(50), '0, "t5 r50", rd);
        chk("t5 addr50 cleared", rd, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: port 0 (CPU MEM stage) and port 1 (debug/DMA loader). Also sequences a full-memory clear, one word per cycle, replacing a single-cycle bulk clear. Sits between the requesters and the memory's MEMread/MEMwrite/A/D/rdata pins. The memory's read path is combinational; its write is on posedge clk.

Parameters:
DATA_WIDTH, 32, data word width
BUS_WIDTH, 10, word address width; memory depth = 2**BUS_WIDTH

Ports:
clk  in  1  system clock, posedge
RST_n  in  1  asynchronous active-low reset
p0_req  in  1  port 0 request; held with p0_we/p0_addr/p0_wdata stable until p0_gnt
p0_we  in  1  port 0: 1=write, 0=read
p0_addr  in  BUS_WIDTH  port 0 word address
p0_wdata  in  DATA_WIDTH  port 0 write data
p0_gnt  out  1  port 0 access performed this cycle
p0_rdata  out  DATA_WIDTH  port 0 registered read data
p0_rvalid  out  1  p0_rdata valid (one cycle)
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rdata, p1_rvalid  same as port 0, for port 1
clr_start  in  1  pulse: begin full-memory clear
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse after the last clear write
mem_read  out  1  to memory MEMread
mem_write  out  1  to memory MEMwrite
mem_A  out  BUS_WIDTH  to memory A
mem_D  out  DATA_WIDTH  to memory D
mem_rdata  in  DATA_WIDTH  from memory rdata

Behaviour:
- Reset (RST_n=0, async): state=IDLE; clear counter=0; RR pointer=port 0; all outputs 0.
- States: IDLE (arbitrate), CLEAR (sequencing). Transitions:
  - IDLE→CLEAR on clr_start=1.
  - CLEAR→IDLE after the write to address 2**BUS_WIDTH-1.
- IDLE arbitration, combinational in the same cycle:
  - Winner selection: if one req is high it wins. If both, port 0 wins (fixed priority).
  - Winner's gnt=1. mem_A=winner addr.
  - Winner read: mem_read=1, mem_write=0.
  - Winner write: mem_write=1, mem_D=winner wdata, mem_read=0.
  - Loser sees gnt=0 and keeps its request asserted.
  - No request: mem_read=mem_write=0, mem_A=0, mem_D=0.
- Read latency: on a read grant, mem_rdata is registered into pX_rdata at the posedge. pX_rvalid=1 for exactly the next cycle. pX_rdata holds its value until the next read by that port.
- Writes: memory captures the write at the posedge ending the gnt cycle. No rvalid is produced.
- Throughput: one access per cycle. Back-to-back grants to the same port are allowed.
- Requester may change req/addr only after the gnt cycle.
- CLEAR state:
  - mem_write=1, mem_D=0, mem_A=counter. Counter increments 0..2**BUS_WIDTH-1.
  - Counter is BUS_WIDTH bits. The last address is detected by counter == all-ones, not by wrap.
  - clr_busy=1 for exactly 2**BUS_WIDTH cycles. No grants during CLEAR; requests stay pending.
  - clr_done=1 in the first IDLE cycle after CLEAR. Arbitration resumes in that same cycle.
- Simultaneous events:
  - clr_start with any req in IDLE: clear wins, no gnt that cycle, CLEAR entered next cycle.
  - In the clr_start cycle, memory outputs are idle (mem_read=mem_write=0).
  - clr_start while in CLEAR is ignored; the counter does not restart.
- Reset mid-clear: aborts immediately; memory is left partially cleared; clr_done is not pulsed.
- Starvation: under fixed priority, port 1 can starve if p0_req is held high continuously. This is accepted behaviour.

Optional Feature:
Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port.
  - After any grant, the pointer moves to the other port.
  - On contention the preferred port wins, so contending ports alternate.
  - Pointer resets to port 0 and is unchanged by CLEAR.
- Undefined: fixed priority, port 0 first; the pointer register is not built.

Decomposition:
- Shared package dmem_pkg:
  - state enum (ST_IDLE, ST_CLEAR)
  - port index constants PORT_CPU=0, PORT_DBG=1
  - default widths DMEM_DATA_W=32, DMEM_ADDR_W=10
- One sub-module: dmem_arb_pick.
  - Purely combinational 2-way grant selector.
  - Inputs: req[1:0], rr_ptr, rr_en. Output: gnt onehot.
  - Reused for other shared resources.
- Clear sequencer stays inline.

Test Plan:
1. p0 write addr 5 = 0xDEADBEEF, then p0 read addr 5 → p0_gnt=1 on each; p0_rvalid=1 one cycle after the read gnt; p0_rdata=0xDEADBEEF.
2. p0 and p1 both request reads of addr 3 and 7, held for 4 cycles.
   - Fixed priority: p0 granted every cycle, p1_gnt=0.
   - With DMEM_ARB_RR_EN: grants alternate p0,p1,p0,p1.
3. Fill addr 0,511,1023 with 0x1 → pulse clr_start → clr_busy high for 1024 cycles; clr_done pulses once; reads of all three return 0x0.
4. p1_req held from the cycle clr_start pulses → no p1_gnt until the clr_done cycle, where p1_gnt=1.
5. RST_n low at clear counter=100 → all outputs 0 asynchronously, no clr_done; addr 200 keeps its pre-clear value.
6. clr_start re-pulsed at counter=50 → ignored; clear still ends after 1024 total cycles.
